// File: rtl/obi_ram_bridge.sv
// OBI data-port terminator driving a single-cycle registered-read RAM port.
// Adds optional LFSR-driven grant stalls and errors out-of-range addresses without touching the RAM.
module obi_ram_bridge #(
  parameter int unsigned ADDR_WIDTH = 22,
  parameter int unsigned STALL_MAX  = 7,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  input  logic [31:0]           data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [31:0]           data_wdata_i,
  output logic                  data_rvalid_o,
  output logic [31:0]           data_rdata_o,
  output logic                  data_err_o,
  input  logic                  stall_en_i,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i
);

  // state | meaning
  // IDLE  | waiting for a request; grants immediately or draws a stall length
  // STALL | holding off the grant until the stall counter reaches zero
  typedef enum logic {IDLE, STALL} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        rvalid_q, err_q, rd_q;
  logic        err_c, gnt_c;
  logic [7:0]  draw_c;

  if (ADDR_WIDTH < 32) begin : g_range
    assign err_c = |data_addr_i[31:ADDR_WIDTH];
  end else begin : g_full
    assign err_c = 1'b0;
  end

  // A modulus of 256 would not fit in 8 bits; the raw byte is already in range then.
  if (STALL_MAX >= 255) begin : g_draw_raw
    assign draw_c = lfsr_q[7:0];
  end else begin : g_draw_mod
    localparam logic [7:0] MOD = 8'(STALL_MAX + 1);
    assign draw_c = lfsr_q[7:0] % MOD;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    gnt_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_req_i) begin
          if (stall_en_i) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
            if (draw_c != 8'd0) begin
              state_d = STALL;
              cnt_d   = draw_c - 8'd1;
            end else begin
              gnt_c = 1'b1;
            end
          end else begin
            gnt_c = 1'b1;
          end
        end
      end
      STALL: begin
        if (!data_req_i) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          gnt_c   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant is combinational from req, so it is also held low while reset is asserted.
  assign data_gnt_o  = gnt_c & rst_ni;
  assign ram_en_o    = data_gnt_o & ~err_c;
  assign ram_addr_o  = data_addr_i[ADDR_WIDTH-1:0];
  assign ram_we_o    = data_we_i;
  assign ram_be_o    = data_be_i;
  assign ram_wdata_o = data_wdata_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      lfsr_q   <= LFSR_SEED;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      rvalid_q <= data_gnt_o;
      err_q    <= err_c;
      rd_q     <= data_gnt_o & ~data_we_i & ~err_c;
    end
  end

  assign data_rvalid_o = rvalid_q;
  assign data_err_o    = rvalid_q & err_q;
  assign data_rdata_o  = rd_q ? ram_rdata_i : 32'h0;

endmodule

// File: tb/tb_obi_ram_bridge.sv
// Directed bench for obi_ram_bridge: a driver pushes expected responses into a
// scoreboard queue, and a monitor pops and compares whenever rvalid is seen.
module tb_obi_ram_bridge;
  localparam int AW = 22;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          data_req = 1'b0;
  logic          data_gnt_o;
  logic [31:0]   data_addr = '0;
  logic          data_we = 1'b0;
  logic [3:0]    data_be = '0;
  logic [31:0]   data_wdata = '0;
  logic          data_rvalid_o;
  logic [31:0]   data_rdata_o;
  logic          data_err_o;
  logic          stall_en = 1'b0;
  logic          ram_en_o;
  logic [AW-1:0] ram_addr_o;
  logic          ram_we_o;
  logic [3:0]    ram_be_o;
  logic [31:0]   ram_wdata_o;
  logic [31:0]   ram_rdata = '0;

  always #5 clk = ~clk;

  obi_ram_bridge #(.ADDR_WIDTH(AW), .STALL_MAX(7), .LFSR_SEED(16'hACE1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .data_req_i(data_req), .data_gnt_o(data_gnt_o), .data_addr_i(data_addr),
    .data_we_i(data_we), .data_be_i(data_be), .data_wdata_i(data_wdata),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .stall_en_i(stall_en), .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o),
    .ram_we_o(ram_we_o), .ram_be_o(ram_be_o), .ram_wdata_o(ram_wdata_o),
    .ram_rdata_i(ram_rdata)
  );

  // Behavioural RAM: byte-enabled write, registered read.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (ram_be_o[b]) mem[ram_addr_o[11:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
      end else begin
        ram_rdata <= mem[ram_addr_o[11:2]];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          gcyc;
  } exp_t;
  exp_t sbq[$];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n && data_rvalid_o === 1'b1) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_rvalid: got rvalid=1 expected no response (cycle %0d)", cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("rsp_rdata", data_rdata_o, mon_e.rdata);
        chk("rsp_err", {31'b0, data_err_o}, {31'b0, mon_e.err});
        chk("rsp_cycle", 32'(cyc), 32'(mon_e.gcyc + 1));
      end
    end
  end

  // exp_lat < 0 means only the STALL_MAX bound is checked.
  task automatic xfer(input logic [31:0] addr, input logic we, input logic [3:0] be,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                      input int exp_lat);
    int lat = 0;
    data_req   = 1'b1;
    data_addr  = addr;
    data_we    = we;
    data_be    = be;
    data_wdata = wd;
    @(negedge clk);
    while (data_gnt_o !== 1'b1) begin
      lat++;
      if (lat > 20) begin
        n_vec++;
        n_bad++;
        $display("FAIL gnt_timeout: got no grant after %0d cycles expected grant (addr 0x%08h)", lat, addr);
        data_req = 1'b0;
        @(posedge clk);
        #1;
        return;
      end
      @(negedge clk);
    end
    if (exp_lat >= 0) chk("gnt_latency", 32'(lat), 32'(exp_lat));
    else chk("gnt_latency_bound", {31'b0, (lat <= 7)}, 32'd1);
    chk("ram_en", {31'b0, ram_en_o}, {31'b0, ~exp_err});
    if (!exp_err) chk("ram_addr", 32'(ram_addr_o), addr & 32'h003F_FFFF);
    sbq.push_back('{exp_rd, exp_err, cyc});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    data_req = 1'b0;
    data_we  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    data_req = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("rst_gnt", {31'b0, data_gnt_o}, 32'd0);
    chk("rst_rvalid", {31'b0, data_rvalid_o}, 32'd0);
    chk("rst_rdata", data_rdata_o, 32'd0);
    chk("rst_err", {31'b0, data_err_o}, 32'd0);
    chk("rst_ram_en", {31'b0, ram_en_o}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected $finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0]   = 32'h1111_1111;
    mem[1]   = 32'h2222_2222;
    mem[128] = 32'h1234_5678;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Stall off: write then read back, same-cycle grants.
    xfer(32'h100, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
    xfer(32'h100, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
    idle();

    // Back-to-back reads.
    xfer(32'h0, 1'b0, 4'hF, 32'h0, 32'h1111_1111, 1'b0, 0);
    xfer(32'h4, 1'b0, 4'hF, 32'h0, 32'h2222_2222, 1'b0, 0);
    idle();

    // Out-of-range read and write: error response, RAM untouched.
    xfer(32'h0040_0000, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, 0);
    xfer(32'hFFFF_FFFC, 1'b1, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b1, 0);
    idle();

    // Byte-lane write then read-merge.
    xfer(32'h200, 1'b1, 4'b0100, 32'h00AB_0000, 32'h0, 1'b0, 0);
    xfer(32'h200, 1'b0, 4'hF, 32'h0, 32'h12AB_5678, 1'b0, 0);
    idle();

    // Stalls from seed 0xACE1: draws 1,0,0,4,6,7 (LFSR 0xACE1,E270,7138,389C,1C4E,0E27).
    do_reset();
    stall_en = 1'b1;
    xfer(32'h0,   1'b0, 4'hF, 32'h0, 32'h1111_1111, 1'b0, 1);
    xfer(32'h4,   1'b0, 4'hF, 32'h0, 32'h2222_2222, 1'b0, 0);
    xfer(32'h100, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
    xfer(32'h200, 1'b0, 4'hF, 32'h0, 32'h12AB_5678, 1'b0, 4);
    xfer(32'h0,   1'b0, 4'hF, 32'h0, 32'h1111_1111, 1'b0, 6);
    xfer(32'h4,   1'b0, 4'hF, 32'h0, 32'h2222_2222, 1'b0, 7);
    for (int k = 0; k < 6; k++) xfer(32'h4, 1'b0, 4'hF, 32'h0, 32'h2222_2222, 1'b0, -1);
    idle();

    // Reset while stalled with counter=3 (fourth draw from seed is 4).
    do_reset();
    xfer(32'h0,   1'b0, 4'hF, 32'h0, 32'h1111_1111, 1'b0, 1);
    xfer(32'h4,   1'b0, 4'hF, 32'h0, 32'h2222_2222, 1'b0, 0);
    xfer(32'h100, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
    data_addr = 32'h200;
    data_we   = 1'b0;
    @(negedge clk);
    chk("stall_entry_gnt", {31'b0, data_gnt_o}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midstall_rst_gnt", {31'b0, data_gnt_o}, 32'd0);
    chk("midstall_rst_rvalid", {31'b0, data_rvalid_o}, 32'd0);
    chk("midstall_rst_ram_en", {31'b0, ram_en_o}, 32'd0);
    data_req = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    xfer(32'h0, 1'b0, 4'hF, 32'h0, 32'h1111_1111, 1'b0, 1);
    idle();

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
